spi_word_tx: RTL

- Host-side SPI transmitter that drives the serial link our Spi receiver block listens on.
- Loads one WIDTH-bit word (plaintext block or key) and shifts it out MSB-first on mosi while holding cs low for exactly WIDTH bit periods.
- Captures the returning miso bits into a parallel word.
- Used in benches and board-level bring-up to feed the AES core's data and key receivers; one instance per chip-select.

---
 rtl/spi_word_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/spi_word_tx.sv
// SPI word transmitter: shifts a WIDTH-bit word out MSB-first on mosi while cs is low,
// collecting miso into a parallel word that is published on completion.
module spi_word_tx #(
    parameter int unsigned WIDTH        = 128,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] tx_data,
    output logic             cs,
    output logic             mosi,
    input  logic             miso,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
    localparam logic [CntW-1:0] ClkLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0]  rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0]  rx_data_q, rx_data_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  rx_next;

    // miso enters at bit 0; the word fills MSB-first like the transmit side
    assign rx_next = {rx_sh_q[WIDTH-2:0], miso};

    // Next-state and registered-output logic; outputs are decided one cycle ahead
    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        clk_cnt_d = clk_cnt_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                // start wins over abort here; abort only matters while shifting
                if (start) begin
                    state_d   = StShift;
                    tx_sh_d   = tx_data;
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    clk_cnt_d = '0;
                    cs_d      = 1'b0;
                    mosi_d    = tx_data[WIDTH-1];
                    busy_d    = 1'b1;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    clk_cnt_d = '0;
                    cs_d      = 1'b1;
                    mosi_d    = 1'b0;
                    busy_d    = 1'b0;
                end else if (clk_cnt_q == ClkLast) begin
                    clk_cnt_d = '0;
                    rx_sh_d   = rx_next;
                    tx_sh_d   = tx_sh_q << 1;
                    if (bit_cnt_q == BitLast) begin
                        state_d   = StDone;
                        bit_cnt_d = '0;
                        rx_data_d = rx_next;
                        cs_d      = 1'b1;
                        mosi_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        mosi_d    = tx_sh_q[WIDTH-2];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StDone: begin
                // start ignored: guarantees cs high for DONE plus one IDLE cycle
                state_d = StIdle;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            clk_cnt_q <= '0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            clk_cnt_q <= clk_cnt_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cs      = cs_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule
